// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file and trap responder for the RV32I pipeline.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   csr_reg_rd/_wr        read / write request from the decoder
//   funct3, csr_addr      Zicsr operation and CSR address
//   rs1_data, zimm        register operand / immediate (also the rs1 index)
//   pc, instr_valid       execute-stage PC and its valid flag
//   is_mret               execute-stage instruction is MRET
//   timer_irq, ext_irq    level interrupt inputs
//   csr_rdata             writeback data (pre-write value)
//   csr_illegal           unimplemented CSR, or effective write to a read-only CSR
//   epc_taken, epc_out    PC redirect request and target
module csr_unit #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
    parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_reg_rd,
    input  logic        csr_reg_wr,
    input  logic [2:0]  funct3,
    input  logic [11:0] csr_addr,
    input  logic [31:0] rs1_data,
    input  logic [4:0]  zimm,
    input  logic [31:0] pc,
    input  logic        instr_valid,
    input  logic        is_mret,
    input  logic        timer_irq,
    input  logic        ext_irq,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    output logic        epc_taken,
    output logic [31:0] epc_out
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE  = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH = 12'hB80;
    localparam logic [11:0] ADDR_MHARTID = 12'hF14;

    localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;
    localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;
    localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;

    logic        mstatus_mie_q,  mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic        mie_mtie_q,     mie_mtie_d;
    logic        mie_meie_q,     mie_meie_d;
    logic [31:0] mtvec_q,        mtvec_d;
    logic [31:0] mepc_q,         mepc_d;
    logic [31:0] mcause_q,       mcause_d;
    logic [63:0] cycle_q,        cycle_d;

    logic [31:0] old_val;
    logic [31:0] operand;
    logic [31:0] new_val;
    logic        implemented;
    logic        read_only;
    logic        eff_wr;
    logic        irq_ext;
    logic        irq_timer;
    logic        irq;
    logic        wr_en;
    logic        mret_go;

    // Address decode and current-value mux, shared by the read port and the
    // read-modify-write path.
    always_comb begin
        old_val     = 32'h0;
        implemented = 1'b1;
        case (csr_addr)
            ADDR_MSTATUS: old_val = {24'h0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
            ADDR_MIE:     old_val = {20'h0, mie_meie_q, 3'b0, mie_mtie_q, 7'b0};
            ADDR_MTVEC:   old_val = mtvec_q;
            ADDR_MEPC:    old_val = mepc_q;
            ADDR_MCAUSE:  old_val = mcause_q;
            ADDR_MIP:     old_val = {20'h0, ext_irq, 3'b0, timer_irq, 7'b0};
            ADDR_MCYCLE:  old_val = cycle_q[31:0];
            ADDR_MCYCLEH: old_val = cycle_q[63:32];
            ADDR_MHARTID: old_val = HART_ID;
            default:      implemented = 1'b0;
        endcase
    end

    always_comb begin
        operand = funct3[2] ? {27'h0, zimm} : rs1_data;
        case (funct3[1:0])
            2'b01:   new_val = operand;
            2'b10:   new_val = old_val | operand;
            2'b11:   new_val = old_val & ~operand;
            default: new_val = old_val;
        endcase
    end

    // RS/RC with a zero source (immediate zero or rs1 index x0) are pure
    // reads, so they neither write nor trip the read-only check.
    assign read_only   = (csr_addr == ADDR_MIP) || (csr_addr == ADDR_MHARTID);
    assign eff_wr      = csr_reg_wr && (funct3[1:0] != 2'b00) && !(funct3[1] && (zimm == 5'd0));
    assign csr_illegal = ((csr_reg_rd || csr_reg_wr) && !implemented) || (eff_wr && read_only);
    assign csr_rdata   = csr_reg_rd ? old_val : 32'h0;

    assign irq_ext   = mstatus_mie_q && mie_meie_q && ext_irq   && instr_valid;
    assign irq_timer = mstatus_mie_q && mie_mtie_q && timer_irq && instr_valid;
    assign irq       = irq_ext || irq_timer;
    assign wr_en     = eff_wr && instr_valid && !csr_illegal && !irq;
    assign mret_go   = is_mret && instr_valid && !irq;

    // Redirect is forced off while reset is asserted so the fetch stage never
    // follows a target computed from registers that are being cleared.
    always_comb begin
        epc_taken = 1'b0;
        epc_out   = 32'h0;
        if (!rst) begin
            if (irq) begin
                epc_taken = 1'b1;
                epc_out   = mtvec_q;
            end else if (mret_go) begin
                epc_taken = 1'b1;
                epc_out   = mepc_q;
            end
        end
    end

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_mtie_d     = mie_mtie_q;
        mie_meie_d     = mie_meie_q;
        mtvec_d        = mtvec_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        cycle_d        = cycle_q + 64'd1;

        if (wr_en) begin
            case (csr_addr)
                ADDR_MSTATUS: begin
                    mstatus_mie_d  = new_val[3];
                    mstatus_mpie_d = new_val[7];
                end
                ADDR_MIE: begin
                    mie_mtie_d = new_val[7];
                    mie_meie_d = new_val[11];
                end
                ADDR_MTVEC:   mtvec_d  = new_val & ALIGN_MASK;
                ADDR_MEPC:    mepc_d   = new_val & ALIGN_MASK;
                ADDR_MCAUSE:  mcause_d = new_val;
                // A write to either half freezes the whole counter that cycle.
                ADDR_MCYCLE:  cycle_d  = {cycle_q[63:32], new_val};
                ADDR_MCYCLEH: cycle_d  = {new_val, cycle_q[31:0]};
                default: ;
            endcase
        end

        if (irq) begin
            mepc_d         = pc & ALIGN_MASK;
            mcause_d       = irq_ext ? CAUSE_EXT : CAUSE_TIMER;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_go) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_mtie_q     <= 1'b0;
            mie_meie_q     <= 1'b0;
            mtvec_q        <= MTVEC_RESET & ALIGN_MASK;
            mepc_q         <= 32'h0;
            mcause_q       <= 32'h0;
            cycle_q        <= 64'h0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_mtie_q     <= mie_mtie_d;
            mie_meie_q     <= mie_meie_d;
            mtvec_q        <= mtvec_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            cycle_q        <= cycle_d;
        end
    end

endmodule

// File: tb/tb_csr_unit.sv
module tb_csr_unit;

    logic        clk;
    logic        rst;
    logic        csr_reg_rd;
    logic        csr_reg_wr;
    logic [2:0]  funct3;
    logic [11:0] csr_addr;
    logic [31:0] rs1_data;
    logic [4:0]  zimm;
    logic [31:0] pc;
    logic        instr_valid;
    logic        is_mret;
    logic        timer_irq;
    logic        ext_irq;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        epc_taken;
    logic [31:0] epc_out;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [2:0] F_RW  = 3'b001;
    localparam logic [2:0] F_RS  = 3'b010;
    localparam logic [2:0] F_RWI = 3'b101;
    localparam logic [2:0] F_RSI = 3'b110;
    localparam logic [2:0] F_RCI = 3'b111;

    csr_unit dut (
        .clk         (clk),
        .rst         (rst),
        .csr_reg_rd  (csr_reg_rd),
        .csr_reg_wr  (csr_reg_wr),
        .funct3      (funct3),
        .csr_addr    (csr_addr),
        .rs1_data    (rs1_data),
        .zimm        (zimm),
        .pc          (pc),
        .instr_valid (instr_valid),
        .is_mret     (is_mret),
        .timer_irq   (timer_irq),
        .ext_irq     (ext_irq),
        .csr_rdata   (csr_rdata),
        .csr_illegal (csr_illegal),
        .epc_taken   (epc_taken),
        .epc_out     (epc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic go_idle();
        csr_reg_rd  = 1'b0;
        csr_reg_wr  = 1'b0;
        funct3      = 3'b000;
        csr_addr    = 12'h000;
        rs1_data    = 32'h0;
        zimm        = 5'd0;
        instr_valid = 1'b0;
        is_mret     = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        go_idle();
    endtask

    task automatic csr_op(input logic [2:0] f3, input logic [11:0] addr,
                          input logic [31:0] rs1, input logic [4:0] zi);
        csr_reg_rd  = 1'b1;
        csr_reg_wr  = 1'b1;
        funct3      = f3;
        csr_addr    = addr;
        rs1_data    = rs1;
        zimm        = zi;
        instr_valid = 1'b1;
        #1;
    endtask

    task automatic csr_read(input logic [11:0] addr, output logic [31:0] val);
        csr_reg_rd  = 1'b1;
        csr_reg_wr  = 1'b0;
        csr_addr    = addr;
        instr_valid = 1'b0;
        is_mret     = 1'b0;
        #1;
        val = csr_rdata;
    endtask

    logic [31:0] v;
    logic [31:0] c1;

    initial begin
        rst       = 1'b1;
        pc        = 32'h0;
        timer_irq = 1'b0;
        ext_irq   = 1'b0;
        go_idle();
        #2;
        csr_read(12'h305, v);
        check_eq("reset_mtvec", v, 32'h0000_0100);
        check_eq("reset_epc_taken", {31'h0, epc_taken}, 32'h0);
        #9 rst = 1'b0;
        tick();

        csr_read(12'hB00, c1);
        tick();
        csr_read(12'hB00, v);
        check_eq("mcycle_incr", v - c1, 32'h1);
        csr_read(12'hF14, v);
        check_eq("mhartid", v, 32'h0);
        tick();

        // CSRRW mtvec: read-before-write, low bits forced to zero.
        csr_op(F_RW, 12'h305, 32'h0000_2003, 5'd0);
        check_eq("mtvec_same_cycle", csr_rdata, 32'h0000_0100);
        check_eq("mtvec_rw_legal", {31'h0, csr_illegal}, 32'h0);
        tick();
        csr_read(12'h305, v);
        check_eq("mtvec_after_rw", v, 32'h0000_2000);
        tick();
        csr_op(F_RW, 12'h305, 32'h0000_0100, 5'd0);
        tick();

        // mstatus set/clear via immediates, then RS with rs1=x0.
        csr_op(F_RSI, 12'h300, 32'h0, 5'd8);
        tick();
        csr_read(12'h300, v);
        check_eq("mstatus_rsi", v, 32'h8);
        tick();
        csr_op(F_RCI, 12'h300, 32'h0, 5'd8);
        tick();
        csr_read(12'h300, v);
        check_eq("mstatus_rci", v, 32'h0);
        tick();
        csr_op(F_RSI, 12'h300, 32'h0, 5'd8);
        tick();
        csr_op(F_RS, 12'h300, 32'hFFFF_FFFF, 5'd0);
        check_eq("rs_x0_legal", {31'h0, csr_illegal}, 32'h0);
        tick();
        csr_read(12'h300, v);
        check_eq("rs_x0_nochange", v, 32'h8);
        tick();

        // mie stores only MTIE/MEIE.
        csr_op(F_RW, 12'h304, 32'hFFFF_FFFF, 5'd0);
        tick();
        csr_read(12'h304, v);
        check_eq("mie_mask", v, 32'h880);
        tick();
        csr_op(F_RW, 12'h304, 32'h80, 5'd0);
        tick();

        // mcycle wrap.
        csr_op(F_RW, 12'hB80, 32'hFFFF_FFFF, 5'd0);
        tick();
        csr_op(F_RW, 12'hB00, 32'hFFFF_FFFE, 5'd0);
        tick();
        csr_read(12'hB00, v);
        check_eq("mcycle_low_loaded", v, 32'hFFFF_FFFE);
        tick();
        tick();
        csr_read(12'hB00, v);
        check_eq("mcycle_wrap_lo", v, 32'h0);
        csr_read(12'hB80, v);
        check_eq("mcycle_wrap_hi", v, 32'h0);
        tick();

        // Illegal accesses.
        csr_read(12'h7C0, v);
        check_eq("unimpl_rdata", v, 32'h0);
        check_eq("unimpl_illegal", {31'h0, csr_illegal}, 32'h1);
        tick();
        csr_op(F_RWI, 12'hF14, 32'h0, 5'd3);
        check_eq("hartid_wr_illegal", {31'h0, csr_illegal}, 32'h1);
        tick();
        csr_read(12'hF14, v);
        check_eq("hartid_unchanged", v, 32'h0);
        tick();
        csr_op(F_RS, 12'h344, 32'hFFFF_FFFF, 5'd0);
        check_eq("mip_rs_x0_legal", {31'h0, csr_illegal}, 32'h0);
        tick();
        timer_irq = 1'b1;
        ext_irq   = 1'b1;
        csr_read(12'h344, v);
        check_eq("mip_live", v, 32'h880);
        timer_irq = 1'b0;
        ext_irq   = 1'b0;
        tick();

        // Timer trap with a concurrent (suppressed) mtvec write.
        timer_irq = 1'b1;
        pc        = 32'h40;
        csr_op(F_RW, 12'h305, 32'h0000_3000, 5'd0);
        check_eq("trap_taken", {31'h0, epc_taken}, 32'h1);
        check_eq("trap_target", epc_out, 32'h100);
        tick();
        timer_irq = 1'b0;
        csr_read(12'h341, v);
        check_eq("trap_mepc", v, 32'h40);
        csr_read(12'h342, v);
        check_eq("trap_mcause", v, 32'h8000_0007);
        csr_read(12'h300, v);
        check_eq("trap_mstatus", v, 32'h80);
        csr_read(12'h305, v);
        check_eq("trap_wr_suppressed", v, 32'h100);
        tick();

        // MRET back.
        is_mret     = 1'b1;
        instr_valid = 1'b1;
        #1;
        check_eq("mret_taken", {31'h0, epc_taken}, 32'h1);
        check_eq("mret_target", epc_out, 32'h40);
        tick();
        csr_read(12'h300, v);
        check_eq("mret_mstatus", v, 32'h88);
        tick();

        // Both interrupts with an MRET: external wins, MRET suppressed.
        csr_op(F_RW, 12'h304, 32'h880, 5'd0);
        tick();
        timer_irq   = 1'b1;
        ext_irq     = 1'b1;
        pc          = 32'h80;
        is_mret     = 1'b1;
        instr_valid = 1'b1;
        #1;
        check_eq("irq_over_mret_target", epc_out, 32'h100);
        tick();
        timer_irq = 1'b0;
        ext_irq   = 1'b0;
        csr_read(12'h342, v);
        check_eq("ext_mcause", v, 32'h8000_000B);
        csr_read(12'h341, v);
        check_eq("ext_mepc", v, 32'h80);
        csr_read(12'h300, v);
        check_eq("ext_mstatus", v, 32'h80);
        tick();

        // Asynchronous reset in the middle of a CSRRW to mepc.
        csr_op(F_RW, 12'h341, 32'h0000_1234, 5'd0);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_mepc_async", csr_rdata, 32'h0);
        csr_reg_wr = 1'b0;
        is_mret    = 1'b1;
        #1;
        check_eq("rst_epc_taken", {31'h0, epc_taken}, 32'h0);
        tick();
        #3 rst = 1'b0;
        csr_read(12'h341, v);
        check_eq("post_rst_mepc", v, 32'h0);
        csr_read(12'h305, v);
        check_eq("post_rst_mtvec", v, 32'h100);
        csr_read(12'h300, v);
        check_eq("post_rst_mstatus", v, 32'h0);
        csr_read(12'h304, v);
        check_eq("post_rst_mie", v, 32'h0);
        csr_read(12'h342, v);
        check_eq("post_rst_mcause", v, 32'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
